// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch-stage state encodings, widths and decoder control bundle
package instruction_fetch_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int JUMP_INDEX_WIDTH = 26;
  typedef enum logic [1:0] {IF_S_REQ = 2'd0, IF_S_WAIT = 2'd1, IF_S_HOLD = 2'd2} if_state_t;
  typedef struct packed {
    logic jr;
    logic jmp;
    logic jal;
    logic branch;
    logic nbranch;
    logic zero;
  } ctrl_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory req/ack bus plus decode valid/ready handshake
interface instruction_fetch_if #(parameter int IMEM_ADDR_WIDTH = 14);
  import instruction_fetch_pkg::*;
  logic imem_req;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
  logic imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] Instruction;
  logic instr_valid;
  logic instr_ready;
  modport master(output imem_req, imem_addr, Instruction, instr_valid, input imem_ack, imem_rdata, instr_ready);
  modport slave(input imem_req, imem_addr, Instruction, instr_valid, output imem_ack, imem_rdata, instr_ready);
endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// instruction_fetch_next_pc_calc: priority mux Jr > Jmp/Jal > taken branch > sequential
module instruction_fetch_next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0]                 i_pc_plus_4,
  input  logic [JUMP_INDEX_WIDTH-1:0] i_jump_index,
  input  logic [31:0]                 i_read_data_1,
  input  logic [31:0]                 i_sign_extend,
  input  ctrl_t                       i_ctrl,
  output logic [31:0]                 o_next_pc,
  output logic                        o_misalign
);
  logic w_taken;
  logic [31:0] w_branch_target;
  logic w_unused;
  assign w_unused = ^i_sign_extend[31:30];
  // Branch and nBranch together is illegal; Branch semantics take precedence
  always_comb begin
    w_taken = i_ctrl.branch ? i_ctrl.zero : (i_ctrl.nbranch & ~i_ctrl.zero);
    w_branch_target = i_pc_plus_4 + {i_sign_extend[29:0], 2'b00};
    o_next_pc = i_ctrl.jr ? {i_read_data_1[31:2], 2'b00}
              : (i_ctrl.jmp | i_ctrl.jal) ? {i_pc_plus_4[31:28], i_jump_index, 2'b00}
              : w_taken ? w_branch_target : i_pc_plus_4;
    o_misalign = i_ctrl.jr & |i_read_data_1[1:0];
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, imem req/ack FSM and instruction hold register for the decoder.
// IFETCH_PERF_CNT_EN adds retired_cnt/stall_cnt performance counters.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IMEM_ADDR_WIDTH = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Jr,
  input  logic                Jmp,
  input  logic                Jal,
  input  logic                Branch,
  input  logic                nBranch,
  input  logic                Zero,
  input  logic [31:0]         Read_data_1,
  input  logic [31:0]         Sign_extend,
  instruction_fetch_if.master bus,
  output logic [31:0]         pc_plus_4,
  output logic [31:0]         link_addr,
  output logic                pc_misalign
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);
  if_state_t r_state, w_next_state;
  logic [31:0] r_pc, r_link, w_next_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic r_req, r_misalign, w_retire, w_ack, w_misalign;
  ctrl_t w_ctrl;
  assign w_ctrl = '{Jr, Jmp, Jal, Branch, nBranch, Zero};
  assign w_retire = r_state == IF_S_HOLD && bus.instr_ready;
  assign w_ack = r_state == IF_S_WAIT && bus.imem_ack;
  assign pc_plus_4 = r_pc + 32'd4;
  assign bus.imem_req = r_req;
  assign bus.imem_addr = r_pc[IMEM_ADDR_WIDTH+1:2];
  assign bus.Instruction = r_instr;
  assign bus.instr_valid = r_state == IF_S_HOLD;
  assign link_addr = r_link;
  assign pc_misalign = r_misalign;
  instruction_fetch_next_pc_calc u_next_pc (
    .i_pc_plus_4  (pc_plus_4),
    .i_jump_index (r_instr[JUMP_INDEX_WIDTH-1:0]),
    .i_read_data_1(Read_data_1),
    .i_sign_extend(Sign_extend),
    .i_ctrl       (w_ctrl),
    .o_next_pc    (w_next_pc),
    .o_misalign   (w_misalign)
  );
  always_comb begin
    w_next_state = r_state;
    w_next_state = r_state == IF_S_REQ ? IF_S_WAIT : w_ack ? IF_S_HOLD : w_retire ? IF_S_REQ : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IF_S_REQ;
    else r_state <= w_next_state;
  // req is registered so it stays low through reset and rises only while waiting on memory
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc <= RESET_PC;
      r_req <= 1'b0;
      r_instr <= '0;
      r_link <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_req <= w_next_state == IF_S_WAIT;
      r_misalign <= w_retire & w_misalign;
      if (w_ack) r_instr <= bus.imem_rdata;
      if (w_retire) r_pc <= w_next_pc;
      if (w_retire && Jal) r_link <= pc_plus_4;
    end
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_retired, r_stall;
  assign retired_cnt = r_retired;
  assign stall_cnt = r_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_retired <= '0;
      r_stall <= '0;
    end else begin
      if (w_retire) r_retired <= r_retired + 32'd1;
      if ((r_state == IF_S_WAIT && !bus.imem_ack) || (r_state == IF_S_HOLD && !bus.instr_ready))
        r_stall <= r_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized fetch sequences checked against an architectural PC model
module tb_instruction_fetch;
  localparam int AW = 14;
  logic clk = 1'b0;
  logic rst_n;
  logic Jr = 0, Jmp = 0, Jal = 0, Branch = 0, nBranch = 0, Zero = 0;
  logic [31:0] Read_data_1 = '0, Sign_extend = '0;
  logic [31:0] pc_plus_4, link_addr;
  logic pc_misalign;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif
  instruction_fetch_if #(.IMEM_ADDR_WIDTH(AW)) bus();
  instruction_fetch #(.RESET_PC(32'h0), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .Jr(Jr), .Jmp(Jmp), .Jal(Jal), .Branch(Branch), .nBranch(nBranch),
    .Zero(Zero), .Read_data_1(Read_data_1), .Sign_extend(Sign_extend), .bus(bus),
    .pc_plus_4(pc_plus_4), .link_addr(link_addr), .pc_misalign(pc_misalign)
`ifdef IFETCH_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  logic mem_en = 1, mem_ack = 0, man_ack = 0;
  logic [31:0] mem_rdata = '0, man_rdata = '0;
  int lat = 0, cyc = 0;
  int errors = 0, checks = 0, n_ret = 0;
  logic [31:0] model_pc = '0, model_link = '0;
  assign bus.imem_ack = mem_en ? mem_ack : man_ack;
  assign bus.imem_rdata = mem_en ? mem_rdata : man_rdata;

  // memory: one-cycle ack pulse lat cycles after it first sees req high; aborts when req drops
  initial forever begin
    @(posedge clk); #1;
    if (!bus.imem_req) begin
      cyc = 0; mem_ack = 0;
    end else begin
      mem_ack = cyc == lat;
      mem_rdata = mem_ack ? mem[bus.imem_addr] : $urandom;
      cyc++;
    end
  end

  function automatic logic [31:0] ref_next(input logic jr, jmp, jal, br, nbr, z, input logic [31:0] rd1, se);
    logic [31:0] p4, ins;
    p4 = model_pc + 32'd4;
    ins = mem[model_pc[AW+1:2]];
    if (jr) return rd1 & ~32'd3;
    if (jmp || jal) return (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} << 2);
    if (br ? z : (nbr && !z)) return p4 + (se << 2);
    return p4;
  endfunction

  task automatic junk();
    {Jr, Jmp, Jal, Branch, nBranch, Zero} = 6'($urandom);
    Read_data_1 = $urandom;
    Sign_extend = $urandom;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.instr_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL %s valid_timeout: got %b want 1", tag, bus.instr_valid); end
  endtask

  task automatic retire(input string tag, input logic jr, jmp, jal, br, nbr, z,
                        input logic [31:0] rd1, se, input int stall);
    logic [31:0] nxt;
    logic mis;
    wait_valid(tag);
    checks += 3;
    if (bus.imem_addr !== model_pc[AW+1:2]) begin errors++; $display("FAIL %s addr: got %h want %h", tag, bus.imem_addr, model_pc[AW+1:2]); end
    if (bus.Instruction !== mem[model_pc[AW+1:2]]) begin errors++; $display("FAIL %s instr: got %h want %h", tag, bus.Instruction, mem[model_pc[AW+1:2]]); end
    if (pc_plus_4 !== model_pc + 32'd4) begin errors++; $display("FAIL %s pc_plus_4: got %h want %h", tag, pc_plus_4, model_pc + 32'd4); end
    for (int s = 0; s < stall; s++) begin junk(); @(negedge clk); end
    {Jr, Jmp, Jal, Branch, nBranch, Zero} = {jr, jmp, jal, br, nbr, z};
    Read_data_1 = rd1;
    Sign_extend = se;
    bus.instr_ready = 1;
    nxt = ref_next(jr, jmp, jal, br, nbr, z, rd1, se);
    mis = jr && (rd1[1:0] != 2'b00);
    if (jal) model_link = model_pc + 32'd4;
    @(negedge clk);
    bus.instr_ready = 0;
    junk();
    checks += 3;
    if (pc_misalign !== mis) begin errors++; $display("FAIL %s misalign: got %b want %b", tag, pc_misalign, mis); end
    if (link_addr !== model_link) begin errors++; $display("FAIL %s link: got %h want %h", tag, link_addr, model_link); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL %s valid_after_retire: got %b want 0", tag, bus.instr_valid); end
    model_pc = nxt;
    n_ret++;
  endtask

  task automatic test_reset();
    bus.instr_ready = 0;
    rst_n = 1; #1 rst_n = 0; #2;
    checks += 6;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst req: got %b want 0", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst valid: got %b want 0", bus.instr_valid); end
    if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL rst instr: got %h want 0", bus.Instruction); end
    if (link_addr !== 32'h0) begin errors++; $display("FAIL rst link: got %h want 0", link_addr); end
    if (pc_misalign !== 1'b0) begin errors++; $display("FAIL rst misalign: got %b want 0", pc_misalign); end
    if (bus.imem_addr !== '0) begin errors++; $display("FAIL rst addr: got %h want 0", bus.imem_addr); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    checks += 2;
    if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL edge1 req: got %b want 1", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL edge1 valid: got %b want 0", bus.instr_valid); end
    @(negedge clk);
    checks += 2;
    if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL edge2 valid: got %b want 1", bus.instr_valid); end
    if (bus.Instruction !== mem[0]) begin errors++; $display("FAIL edge2 instr: got %h want %h", bus.Instruction, mem[0]); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) retire("seq", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch();
    retire("br_set", 1, 0, 0, 0, 0, 0, 32'h10, 0, 0);
    retire("beq_taken", 0, 0, 0, 1, 0, 1, 0, 32'd3, 1);
    wait_valid("beq_taken");
    checks++;
    if (bus.imem_addr !== 14'h8) begin errors++; $display("FAIL beq_taken target: got %h want 8", bus.imem_addr); end
    retire("br_set2", 1, 0, 0, 0, 0, 0, 32'h10, 0, 0);
    retire("beq_not", 0, 0, 0, 1, 0, 0, 0, 32'd3, 0);
    wait_valid("beq_not");
    checks++;
    if (bus.imem_addr !== 14'h5) begin errors++; $display("FAIL beq_not target: got %h want 5", bus.imem_addr); end
  endtask

  task automatic test_jal();
    retire("jal_set", 1, 0, 0, 0, 0, 0, 32'h40, 0, 0);
    retire("jal", 0, 0, 1, 0, 0, 0, 0, 0, 2);
    wait_valid("jal");
    checks += 2;
    if (link_addr !== 32'h44) begin errors++; $display("FAIL jal link: got %h want 44", link_addr); end
    if (bus.imem_addr !== 14'h100) begin errors++; $display("FAIL jal target: got %h want 100", bus.imem_addr); end
  endtask

  task automatic test_jr();
    retire("jr_mis", 1, 0, 0, 0, 0, 0, 32'h1235, 0, 0);
    @(negedge clk);
    checks++;
    if (pc_misalign !== 1'b0) begin errors++; $display("FAIL jr_mis pulse_end: got %b want 0", pc_misalign); end
    wait_valid("jr_mis");
    checks++;
    if (bus.imem_addr !== 14'h48D) begin errors++; $display("FAIL jr_mis target: got %h want 48d", bus.imem_addr); end
    retire("jr_jmp", 1, 1, 0, 0, 0, 0, 32'h88, 0, 0);
    wait_valid("jr_jmp");
    checks++;
    if (bus.imem_addr !== 14'h22) begin errors++; $display("FAIL jr_jmp target: got %h want 22", bus.imem_addr); end
  endtask

  task automatic test_hold();
    logic [31:0] ins, pp4;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] s0;
`endif
    wait_valid("hold");
    ins = bus.Instruction;
    pp4 = pc_plus_4;
`ifdef IFETCH_PERF_CNT_EN
    s0 = stall_cnt;
`endif
    mem_en = 0;
    for (int i = 0; i < 3; i++) begin
      man_ack = ~man_ack;
      man_rdata = $urandom;
      junk();
      bus.instr_ready = 0;
      @(negedge clk);
      checks += 3;
      if (bus.Instruction !== ins) begin errors++; $display("FAIL hold instr: got %h want %h", bus.Instruction, ins); end
      if (pc_plus_4 !== pp4) begin errors++; $display("FAIL hold pc_plus_4: got %h want %h", pc_plus_4, pp4); end
      if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL hold valid: got %b want 1", bus.instr_valid); end
    end
`ifdef IFETCH_PERF_CNT_EN
    checks++;
    if (stall_cnt - s0 !== 32'd3) begin errors++; $display("FAIL hold stall_cnt: got %0d want 3", stall_cnt - s0); end
`endif
    man_ack = 0;
    mem_en = 1;
    retire("hold_rel", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    retire("wrap_set", 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    wait_valid("wrap");
    checks++;
    if (pc_plus_4 !== 32'h0) begin errors++; $display("FAIL wrap pc_plus_4: got %h want 0", pc_plus_4); end
    retire("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_valid("wrap");
    checks++;
    if (bus.imem_addr !== '0) begin errors++; $display("FAIL wrap target: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_reset_mid_wait();
    lat = 3;
    retire("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL midwait req: got %b want 1", bus.imem_req); end
    if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL midwait valid: got %b want 0", bus.instr_valid); end
    rst_n = 0; #1;
    checks += 3;
    if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL midrst req: got %b want 0", bus.imem_req); end
    if (bus.Instruction !== 32'h0) begin errors++; $display("FAIL midrst instr: got %h want 0", bus.Instruction); end
    if (link_addr !== 32'h0) begin errors++; $display("FAIL midrst link: got %h want 0", link_addr); end
    mem_en = 0; man_ack = 1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk); lat = 0; rst_n = 1;
    @(negedge clk); mem_en = 1; man_ack = 0;
    @(negedge clk);
    checks += 3;
    if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL restart valid: got %b want 1", bus.instr_valid); end
    if (bus.imem_addr !== '0) begin errors++; $display("FAIL restart addr: got %h want 0", bus.imem_addr); end
    if (bus.Instruction !== mem[0]) begin errors++; $display("FAIL restart instr: got %h want %h", bus.Instruction, mem[0]); end
    model_pc = 0; model_link = 0; n_ret = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int k;
      logic z;
      logic [31:0] rd1, se;
      k = $urandom_range(0, 5);
      z = 1'($urandom);
      rd1 = $urandom;
      se = ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed(8'($urandom)));
      lat = $urandom_range(0, 3);
      retire("rand", k == 1, k == 2, k == 3, k == 4, k == 5, z, rd1, se, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[16] = 32'h0C00_0100;
    test_reset();
    test_sequential();
    test_branch();
    test_jal();
    test_jr();
    test_hold();
    test_wrap();
    test_reset_mid_wait();
    test_random();
`ifdef IFETCH_PERF_CNT_EN
    checks++;
    if (retired_cnt !== n_ret) begin errors++; $display("FAIL retired_cnt: got %0d want %0d", retired_cnt, n_ret); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
